fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequencing FSM for the instruction fetch stage. It replaces the free-running fetch enable with explicit states: IDLE, CPU_GO, STALL, FLUSH and CPU_DONE. Each cycle it decides whether the PC advances, redirects or holds, gates the instruction-memory request, and flushes the front-end pipeline registers after a taken branch. It sits between the hazard/execute logic and the fetch stage, and drives the fetch stage's pc_stall and sel_next_pc inputs.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles flush is asserted after a redirect (legal range 1..15).
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
clk  input  1  core clock, rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse that starts fetching; honoured only in IDLE.
hazard_stall  input  1  downstream stage requests the PC to be held.
branch_taken  input  1  execute stage resolved a redirect (jump or taken branch).
halt_req  input  1  ecall/ebreak retired; stop fetching.
inst_gnt  input  1  instruction memory accepted the current request.
inst_request  output  1  instruction fetch request.
pc_stall  output  1  1 = fetch stage holds PC.
sel_next_pc  output  1  1 = PC loads the ALU target this cycle.
flush  output  1  kill the IF/ID and ID/EX contents.
cpu_done  output  1  sticky halt indication.
state  output  3  current state: IDLE=0, CPU_GO=1, STALL=2, FLUSH=3, CPU_DONE=4.
stall_cnt  output  CNT_W  saturating count of stalled active cycles.

Behaviour:
- Reset values (async, immediate on rstn low):
  - state=IDLE, inst_request=0, pc_stall=1, sel_next_pc=0, flush=0, cpu_done=0, stall_cnt=0.
  - The internal flush counter is cleared.
  - Reset mid-operation abandons any state immediately.
- State is registered. Outputs are decoded from the registered state plus same-cycle inputs (Mealy). There is no added latency.
- Input priority in CPU_GO and STALL: halt_req > branch_taken > hazard_stall.
- IDLE:
  - inst_request=0, pc_stall=1.
  - start=1 -> CPU_GO.
  - All other inputs are ignored.
- CPU_GO:
  - inst_request=1.
  - pc_stall = ~inst_gnt | hazard_stall, unless a redirect is taken.
  - halt_req -> CPU_DONE, with pc_stall=1 that cycle.
  - branch_taken -> FLUSH. That cycle: sel_next_pc=1 and pc_stall=0 regardless of inst_gnt or hazard_stall. Flush counter is loaded with FLUSH_CYCLES.
  - hazard_stall -> STALL.
  - Otherwise stay in CPU_GO.
- STALL:
  - inst_request=1, pc_stall=1.
  - halt_req -> CPU_DONE.
  - branch_taken -> FLUSH, with the same redirect outputs as in CPU_GO.
  - hazard_stall=0 -> CPU_GO. pc_stall is already 0 in that exit cycle if inst_gnt=1.
- FLUSH:
  - flush=1, inst_request=1, pc_stall=~inst_gnt.
  - The counter decrements every cycle. When the counter equals 1 -> CPU_GO.
  - branch_taken, halt_req and hazard_stall are ignored, because they originate from instructions being flushed.
  - flush is asserted for exactly FLUSH_CYCLES cycles.
- CPU_DONE:
  - inst_request=0, pc_stall=1, cpu_done=1.
  - Terminal state; only rstn exits it. start is ignored.
- sel_next_pc is 1 only in a redirect-accept cycle, never in IDLE, FLUSH or CPU_DONE.
- stall_cnt:
  - Increments by 1 on each cycle where pc_stall=1 and state is CPU_GO, STALL or FLUSH.
  - Saturates at 2^CNT_W-1; no wrap.
  - Holds its value in IDLE and CPU_DONE.
- Simultaneous start and rstn deassert edge: start is sampled only on clock edges while rstn=1.

Test Plan:
- Reset, then start pulse at cycle 3 with inst_gnt=1 -> state 0 through cycle 3; state=1 from cycle 4; inst_request=1 and pc_stall=0 every cycle thereafter; stall_cnt stays 0.
- In CPU_GO, hazard_stall high for 3 cycles -> state=2 for 3 cycles; pc_stall=1 for those 3 cycles; back to CPU_GO with pc_stall=0; stall_cnt=3.
- branch_taken=1 and hazard_stall=1 in the same cycle (FLUSH_CYCLES=2) -> that cycle sel_next_pc=1 and pc_stall=0; flush=1 for exactly 2 cycles; branch_taken pulses during FLUSH are ignored; then state=1.
- halt_req and branch_taken together in STALL -> next state=4; sel_next_pc stays 0; cpu_done=1 and inst_request=0 persist; a later start pulse has no effect.
- inst_gnt held low for 70000 cycles in CPU_GO with CNT_W=16 -> stall_cnt saturates at 65535; pc_stall=1 throughout.
- rstn asserted mid-FLUSH -> outputs return to reset values immediately, without waiting for a clock edge; after release, a start pulse is required to resume.

Source files
------------

// File: rtl/fetch_controller_if.sv
// ---------------------------------------------------------------------------
// fetch_controller_if
//
// Purpose: bundles the handshake between the fetch sequencing FSM, the
// hazard/execute logic that feeds it, and the fetch stage it steers.
//
// Modports:
//   master - the fetch controller: samples the control inputs and drives
//            the fetch-stage controls, status and performance counter.
//   slave  - the surrounding pipeline: drives start/hazard/branch/halt and
//            the instruction-memory grant, observes everything else.
//
// Signals:
//   start, hazard_stall, branch_taken, halt_req, inst_gnt   (slave -> master)
//   inst_request, pc_stall, sel_next_pc, flush, cpu_done,
//   state[2:0], stall_cnt[CNT_W-1:0]                        (master -> slave)
// ---------------------------------------------------------------------------
interface fetch_controller_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             hazard_stall;
    logic             branch_taken;
    logic             halt_req;
    logic             inst_gnt;

    logic             inst_request;
    logic             pc_stall;
    logic             sel_next_pc;
    logic             flush;
    logic             cpu_done;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  start, hazard_stall, branch_taken, halt_req, inst_gnt,
        output inst_request, pc_stall, sel_next_pc, flush, cpu_done,
               state, stall_cnt
    );

    modport slave (
        output start, hazard_stall, branch_taken, halt_req, inst_gnt,
        input  inst_request, pc_stall, sel_next_pc, flush, cpu_done,
               state, stall_cnt
    );
endinterface

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Purpose: sequencing FSM for the instruction fetch stage. Each cycle it
// decides whether the PC advances, redirects to the ALU target or holds,
// gates the instruction-memory request, and flushes the IF/ID and ID/EX
// registers for FLUSH_CYCLES cycles after a taken redirect.
//
// Parameters:
//   FLUSH_CYCLES - cycles of flush after a redirect (1..15)
//   CNT_W        - width of the saturating stall-cycle counter; must match
//                  the CNT_W of the connected interface
//
// Ports:
//   clk  - core clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - fetch_controller_if.master (control inputs, fetch-stage controls,
//          state, cpu_done, stall_cnt)
//
// Outputs are Mealy: decoded from the registered state plus same-cycle
// inputs, so a redirect or stall takes effect in the cycle it is raised.
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rstn,
    fetch_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_GO   = 3'd1,
        S_STALL    = 3'd2,
        S_FLUSH    = 3'd3,
        S_CPU_DONE = 3'd4
    } state_e;

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Decoded outputs, kept local so the counter logic can reuse pc_stall.
    logic inst_request_c;
    logic pc_stall_c;
    logic sel_next_pc_c;
    logic flush_c;
    logic cpu_done_c;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // Priority while active: halt_req > branch_taken > hazard_stall.
    // -----------------------------------------------------------------------
    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CPU_GO;
            end

            S_CPU_GO: begin
                if (bus.halt_req) begin
                    state_d = S_CPU_DONE;
                end else if (bus.branch_taken) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (bus.hazard_stall) begin
                    state_d = S_STALL;
                end
            end

            S_STALL: begin
                if (bus.halt_req) begin
                    state_d = S_CPU_DONE;
                end else if (bus.branch_taken) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (!bus.hazard_stall) begin
                    state_d = S_CPU_GO;
                end
            end

            S_FLUSH: begin
                // Redirect/halt/hazard here come from wrong-path instructions
                // that are being killed, so only the counter matters.
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q == 4'd1) state_d = S_CPU_GO;
            end

            S_CPU_DONE: begin
                state_d = S_CPU_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (Mealy)
    // -----------------------------------------------------------------------
    always_comb begin
        inst_request_c = 1'b0;
        pc_stall_c     = 1'b1;
        sel_next_pc_c  = 1'b0;
        flush_c        = 1'b0;
        cpu_done_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                inst_request_c = 1'b0;
                pc_stall_c     = 1'b1;
            end

            // CPU_GO and STALL decode identically: while hazard_stall is held
            // in STALL the stall term is already 1, and on the exit cycle the
            // PC may advance as soon as the grant arrives.
            S_CPU_GO, S_STALL: begin
                inst_request_c = 1'b1;
                if (bus.halt_req) begin
                    pc_stall_c = 1'b1;
                end else if (bus.branch_taken) begin
                    // Redirect accept: the target load must not be blocked
                    // by a missing grant or by the hazard it overrides.
                    sel_next_pc_c = 1'b1;
                    pc_stall_c    = 1'b0;
                end else begin
                    pc_stall_c = ~bus.inst_gnt | bus.hazard_stall;
                end
            end

            S_FLUSH: begin
                flush_c        = 1'b1;
                inst_request_c = 1'b1;
                pc_stall_c     = ~bus.inst_gnt;
            end

            S_CPU_DONE: begin
                inst_request_c = 1'b0;
                pc_stall_c     = 1'b1;
                cpu_done_c     = 1'b1;
            end

            default: begin
                inst_request_c = 1'b0;
                pc_stall_c     = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stall-cycle performance counter: counts held-PC cycles only while
    // fetching is active, and sticks at all-ones instead of wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_CPU_GO || state_q == S_STALL || state_q == S_FLUSH)
            && pc_stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    assign bus.inst_request = inst_request_c;
    assign bus.pc_stall     = pc_stall_c;
    assign bus.sel_next_pc  = sel_next_pc_c;
    assign bus.flush        = flush_c;
    assign bus.cpu_done     = cpu_done_c;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//
// Self-checking bench for fetch_controller (FLUSH_CYCLES=2, CNT_W=16).
// Inputs are driven on the falling edge; the expected output record is
// pushed to a scoreboard queue at that moment and popped and compared 1 ns
// later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    typedef struct packed {
        logic start;
        logic hazard;
        logic branch;
        logic halt;
        logic gnt;
    } stim_t;

    // Field order: state, inst_request, pc_stall, sel_next_pc, flush,
    // cpu_done, stall_cnt.
    typedef struct packed {
        logic [2:0]  state;
        logic        req;
        logic        stall;
        logic        sel;
        logic        fl;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk;
    logic rstn;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    fetch_controller_if #(.CNT_W(CNT_W)) bus ();

    fetch_controller #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the whole run is ~71k cycles (~710 us).
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
        $fatal(1, "timeout");
    end

    function automatic stim_t mk_s(input logic start, hazard, branch, halt, gnt);
        mk_s = '{start: start, hazard: hazard, branch: branch, halt: halt, gnt: gnt};
    endfunction

    function automatic exp_t mk_e(input logic [2:0] st, input logic req, stall, sel,
                                  fl, done, input logic [15:0] cnt);
        mk_e = '{state: st, req: req, stall: stall, sel: sel, fl: fl, done: done,
                 cnt: cnt};
    endfunction

    function automatic exp_t sample();
        sample = '{state: bus.state, req: bus.inst_request, stall: bus.pc_stall,
                   sel: bus.sel_next_pc, fl: bus.flush, done: bus.cpu_done,
                   cnt: bus.stall_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.start        = s.start;
        bus.hazard_stall = s.hazard;
        bus.branch_taken = s.branch;
        bus.halt_req     = s.halt;
        bus.inst_gnt     = s.gnt;
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic compare(input string name);
        exp_t exp;
        if (sb_q.size() == 0) begin
            check({name, " (scoreboard empty)"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check(name, 32'(sample()), 32'(exp));
        end
    endtask

    task automatic step(input stim_t s, input exp_t e, input string name);
        @(negedge clk);
        drive(s);
        sb_q.push_back(e);
        #1;
        compare(name);
    endtask

    // Assert reset away from any clock edge, check outputs immediately,
    // then release on a falling edge.
    task automatic apply_reset(input string name);
        #2;
        rstn = 1'b0;
        sb_q.push_back(mk_e(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        #1;
        compare(name);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    vec_t tbl[19];

    initial begin
        int bad_stall;

        // ------------------------------------------------------------------
        // Main scenario table: {start,hazard,branch,halt,gnt} -> outputs
        // ------------------------------------------------------------------
        //               start haz br  halt gnt     st   req stl sel fl dn cnt
        tbl[0]  = '{mk_s(0,0,0,0,0), mk_e(3'd0, 0,1,0,0,0, 16'd0)}; // idle
        tbl[1]  = '{mk_s(0,1,1,1,1), mk_e(3'd0, 0,1,0,0,0, 16'd0)}; // idle ignores
        tbl[2]  = '{mk_s(1,0,0,0,1), mk_e(3'd0, 0,1,0,0,0, 16'd0)}; // start
        tbl[3]  = '{mk_s(0,0,0,0,1), mk_e(3'd1, 1,0,0,0,0, 16'd0)}; // go
        tbl[4]  = '{mk_s(0,1,0,0,1), mk_e(3'd1, 1,1,0,0,0, 16'd0)}; // hazard 1
        tbl[5]  = '{mk_s(0,1,0,0,1), mk_e(3'd2, 1,1,0,0,0, 16'd1)}; // hazard 2
        tbl[6]  = '{mk_s(0,1,0,0,1), mk_e(3'd2, 1,1,0,0,0, 16'd2)}; // hazard 3
        tbl[7]  = '{mk_s(0,0,0,0,1), mk_e(3'd2, 1,0,0,0,0, 16'd3)}; // stall exit
        tbl[8]  = '{mk_s(0,0,0,0,1), mk_e(3'd1, 1,0,0,0,0, 16'd3)}; // go
        tbl[9]  = '{mk_s(0,0,0,0,0), mk_e(3'd1, 1,1,0,0,0, 16'd3)}; // no grant
        tbl[10] = '{mk_s(0,1,1,0,1), mk_e(3'd1, 1,0,1,0,0, 16'd4)}; // br+hazard
        tbl[11] = '{mk_s(0,0,1,0,1), mk_e(3'd3, 1,0,0,1,0, 16'd4)}; // flush 1
        tbl[12] = '{mk_s(0,0,1,1,0), mk_e(3'd3, 1,1,0,1,0, 16'd4)}; // flush 2
        tbl[13] = '{mk_s(0,0,0,0,1), mk_e(3'd1, 1,0,0,0,0, 16'd5)}; // back to go
        tbl[14] = '{mk_s(0,1,0,0,1), mk_e(3'd1, 1,1,0,0,0, 16'd5)}; // to stall
        tbl[15] = '{mk_s(0,1,1,1,1), mk_e(3'd2, 1,1,0,0,0, 16'd6)}; // halt+br
        tbl[16] = '{mk_s(0,0,0,0,1), mk_e(3'd4, 0,1,0,0,1, 16'd7)}; // done
        tbl[17] = '{mk_s(1,0,0,0,1), mk_e(3'd4, 0,1,0,0,1, 16'd7)}; // start ign.
        tbl[18] = '{mk_s(0,0,1,0,0), mk_e(3'd4, 0,1,0,0,1, 16'd7)}; // sticky

        rstn = 1'b0;
        drive(mk_s(0, 0, 0, 0, 0));
        sb_q.push_back(mk_e(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
        #1;
        compare("reset_values");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].s, tbl[i].e, $sformatf("table[%0d]", i));
        end

        // ------------------------------------------------------------------
        // Reset mid-FLUSH, then restart and redirect out of STALL.
        // ------------------------------------------------------------------
        apply_reset("reset_from_done");
        step(mk_s(1,0,0,0,1), mk_e(3'd0, 0,1,0,0,0, 16'd0), "rf_start");
        step(mk_s(0,0,1,0,1), mk_e(3'd1, 1,0,1,0,0, 16'd0), "rf_redirect");
        step(mk_s(0,0,0,0,1), mk_e(3'd3, 1,0,0,1,0, 16'd0), "rf_flush1");
        apply_reset("reset_mid_flush");
        step(mk_s(0,0,0,0,1), mk_e(3'd0, 0,1,0,0,0, 16'd0), "rf_idle1");
        step(mk_s(0,0,0,0,1), mk_e(3'd0, 0,1,0,0,0, 16'd0), "rf_idle2");
        step(mk_s(1,0,0,0,1), mk_e(3'd0, 0,1,0,0,0, 16'd0), "rf_restart");
        step(mk_s(0,0,0,0,1), mk_e(3'd1, 1,0,0,0,0, 16'd0), "rf_go");
        step(mk_s(0,1,0,0,1), mk_e(3'd1, 1,1,0,0,0, 16'd0), "rf_hazard");
        step(mk_s(0,1,1,0,0), mk_e(3'd2, 1,0,1,0,0, 16'd1), "stall_redirect");
        step(mk_s(0,0,0,0,1), mk_e(3'd3, 1,0,0,1,0, 16'd1), "sr_flush1");
        step(mk_s(0,0,0,0,1), mk_e(3'd3, 1,0,0,1,0, 16'd1), "sr_flush2");
        step(mk_s(0,0,0,0,1), mk_e(3'd1, 1,0,0,0,0, 16'd1), "sr_go");

        // ------------------------------------------------------------------
        // Grant withheld for 70000 cycles: counter must saturate at 65535.
        // ------------------------------------------------------------------
        apply_reset("reset_before_sat");
        step(mk_s(1,0,0,0,1), mk_e(3'd0, 0,1,0,0,0, 16'd0), "sat_start");
        bad_stall = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            drive(mk_s(0, 0, 0, 0, 0));
            #1;
            if (bus.pc_stall !== 1'b1) bad_stall++;
            if (i == 1000) check("sat_count_1000", 32'(bus.stall_cnt), 32'd1000);
        end
        check("sat_pc_stall_held", 32'(bad_stall), 32'd0);
        step(mk_s(0,0,0,0,0), mk_e(3'd1, 1,1,0,0,0, 16'hFFFF), "sat_value");
        step(mk_s(0,0,0,0,0), mk_e(3'd1, 1,1,0,0,0, 16'hFFFF), "sat_no_wrap");

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
